// File: rtl/regfile_access_ctrl_pkg.sv
// Shared widths, arbiter encodings and request types for the register-file access controller.
// The copperv_h macros are defined here (guarded) so every file compiled after this one sees them.
`ifndef COPPERV_H_RF_ACCESS
`define COPPERV_H_RF_ACCESS
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`define ARB_WB_FAVOR 1'b0
`define ARB_RD_FAVOR 1'b1
`ifndef WB_BURST_MAX
`define WB_BURST_MAX 4
`endif
`endif

package regfile_access_ctrl_pkg;

   localparam int REG_WIDTH        = `REG_WIDTH;
   localparam int DATA_WIDTH       = `DATA_WIDTH;
   localparam int REG_COUNT_DEF    = 2 ** REG_WIDTH;
   localparam int WB_BURST_MAX_DEF = `WB_BURST_MAX;

   typedef enum logic [0:0] {
      ARB_WB_FAVOR = `ARB_WB_FAVOR,
      ARB_RD_FAVOR = `ARB_RD_FAVOR
   } arb_state_t;

   typedef struct packed {
      logic [REG_WIDTH-1:0] rs1;
      logic [REG_WIDTH-1:0] rs2;
      logic                 use_rs2;
      logic [REG_WIDTH-1:0] rd;
      logic                 rd_en;
   } rd_req_t;

   // x0 is hardwired: it never becomes pending and is never written.
   function automatic logic reg_nz(input logic [REG_WIDTH-1:0] idx);
      return idx != '0;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits with set (read grant), clear (writeback) and flush,
// plus hazard lookups for the three indices of an operand-read request.
module regfile_scoreboard
   import regfile_access_ctrl_pkg::*;
#(
   parameter int REG_COUNT = REG_COUNT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_flush,
   input  logic                 i_set_en,
   input  logic [REG_WIDTH-1:0] i_set_idx,
   input  logic                 i_clr_en,
   input  logic [REG_WIDTH-1:0] i_clr_idx,
   input  logic [REG_WIDTH-1:0] i_look_rs1,
   input  logic [REG_WIDTH-1:0] i_look_rs2,
   input  logic [REG_WIDTH-1:0] i_look_rd,
   output logic                 o_pend_rs1,
   output logic                 o_pend_rs2,
   output logic                 o_pend_rd,
   output logic [REG_COUNT-1:0] o_pending
);

   logic [REG_COUNT-1:0] w_pending;

   assign w_pending[0] = 1'b0;

   // Set and clear never target the same bit in one cycle, so their order here is arbitrary.
   for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_bit
      logic r_bit;

      always_ff @(posedge clk) begin
         if (!rst || i_flush) begin
            r_bit <= 1'b0;
         end else if (i_set_en && (i_set_idx == REG_WIDTH'(gi))) begin
            r_bit <= 1'b1;
         end else if (i_clr_en && (i_clr_idx == REG_WIDTH'(gi))) begin
            r_bit <= 1'b0;
         end
      end

      assign w_pending[gi] = r_bit;
   end

   assign o_pend_rs1 = w_pending[i_look_rs1];
   assign o_pend_rs2 = w_pending[i_look_rs2];
   assign o_pend_rd  = w_pending[i_look_rd];
   assign o_pending  = w_pending;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Single-port register-file sequencer: one writeback or operand read per cycle,
// hazard stalls from the pending-write scoreboard, and a bounded writeback-burst arbiter.
module regfile_access_ctrl
   import regfile_access_ctrl_pkg::*;
#(
   parameter int REG_COUNT    = REG_COUNT_DEF,
   parameter int WB_BURST_MAX = WB_BURST_MAX_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  rd_req_valid,
   output logic                  rd_req_ready,
   input  logic [REG_WIDTH-1:0]  rd_req_rs1,
   input  logic [REG_WIDTH-1:0]  rd_req_rs2,
   input  logic                  rd_req_use_rs2,
   input  logic [REG_WIDTH-1:0]  rd_req_rd,
   input  logic                  rd_req_rd_en,
   output logic                  rd_resp_valid,
   input  logic                  wb_valid,
   output logic                  wb_ready,
   input  logic [REG_WIDTH-1:0]  wb_rd,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  rf_rd_en,
   output logic [REG_WIDTH-1:0]  rf_rd,
   output logic [DATA_WIDTH-1:0] rf_rd_din,
   output logic                  rf_rs1_en,
   output logic                  rf_rs2_en,
   output logic [REG_WIDTH-1:0]  rf_rs1,
   output logic [REG_WIDTH-1:0]  rf_rs2,
   output logic [REG_COUNT-1:0]  pending_mask,
   output logic                  wb_unexpected
);

   localparam int CNT_W = $clog2(WB_BURST_MAX + 1);

   arb_state_t       r_state;
   logic [CNT_W-1:0] r_burst_cnt;
   logic             r_rd_resp_valid;
   logic             r_wb_unexpected;

   rd_req_t          w_req;
   logic             w_pend_rs1;
   logic             w_pend_rs2;
   logic             w_pend_rd;
   logic             w_hazard;
   logic             w_rd_elig;
   logic             w_rd_grant;
   logic             w_wb_grant;
   logic             w_wb_unexp_hit;
   logic [CNT_W-1:0] w_burst_inc;

   assign w_req = '{
      rs1:     rd_req_rs1,
      rs2:     rd_req_rs2,
      use_rs2: rd_req_use_rs2,
      rd:      rd_req_rd,
      rd_en:   rd_req_rd_en
   };

   regfile_scoreboard #(
      .REG_COUNT (REG_COUNT)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (flush),
      .i_set_en   (w_rd_grant & w_req.rd_en),
      .i_set_idx  (w_req.rd),
      .i_clr_en   (w_wb_grant),
      .i_clr_idx  (wb_rd),
      .i_look_rs1 (w_req.rs1),
      .i_look_rs2 (w_req.rs2),
      .i_look_rd  (w_req.rd),
      .o_pend_rs1 (w_pend_rs1),
      .o_pend_rs2 (w_pend_rs2),
      .o_pend_rd  (w_pend_rd),
      .o_pending  (pending_mask)
   );

   assign w_hazard = w_pend_rs1
                   | (w_req.use_rs2 & w_pend_rs2)
                   | (w_req.rd_en & reg_nz(w_req.rd) & w_pend_rd);

   assign w_rd_elig = rst & rd_req_valid & ~w_hazard & ~flush;

   // A waiting read only beats writeback once it has been passed over WB_BURST_MAX times.
   assign w_rd_grant = w_rd_elig & ((r_state == ARB_RD_FAVOR) | ~wb_valid);
   assign w_wb_grant = rst & wb_valid & ~w_rd_grant;

   assign w_wb_unexp_hit = w_wb_grant & reg_nz(wb_rd) & ~pending_mask[wb_rd];
   assign w_burst_inc    = r_burst_cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state         <= ARB_WB_FAVOR;
         r_burst_cnt     <= '0;
         r_rd_resp_valid <= 1'b0;
         r_wb_unexpected <= 1'b0;
      end else begin
         r_rd_resp_valid <= w_rd_grant;
         if (w_wb_unexp_hit) begin
            r_wb_unexpected <= 1'b1;
         end
         case (r_state)
            ARB_WB_FAVOR: begin
               if (!w_rd_elig || w_rd_grant) begin
                  r_burst_cnt <= '0;
               end else if (w_wb_grant) begin
                  r_burst_cnt <= w_burst_inc;
                  if (w_burst_inc == CNT_W'(WB_BURST_MAX)) begin
                     r_state <= ARB_RD_FAVOR;
                  end
               end
            end
            ARB_RD_FAVOR: begin
               if (w_rd_grant) begin
                  r_state     <= ARB_WB_FAVOR;
                  r_burst_cnt <= '0;
               end
            end
            default: begin
               r_state     <= ARB_WB_FAVOR;
               r_burst_cnt <= '0;
            end
         endcase
      end
   end

   assign rd_req_ready  = w_rd_grant;
   assign wb_ready      = w_wb_grant;

   assign rf_rd_en      = w_wb_grant & reg_nz(wb_rd);
   assign rf_rd         = wb_rd;
   assign rf_rd_din     = wb_data;
   assign rf_rs1_en     = w_rd_grant;
   assign rf_rs2_en     = w_rd_grant & w_req.use_rs2;
   assign rf_rs1        = w_req.rs1;
   assign rf_rs2        = w_req.rs2;

   // Gated so a reset arriving while a read is in flight drops its response.
   assign rd_resp_valid = r_rd_resp_valid & rst;
   assign wb_unexpected = r_wb_unexpected;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Random + directed bench: a behavioural model predicts grants and scoreboard state each cycle,
// and a monitor checks read responses (timing and register-file data) from an expectation queue.
module tb_regfile_access_ctrl;
   import regfile_access_ctrl_pkg::*;

   localparam int RW     = REG_WIDTH;
   localparam int DW     = DATA_WIDTH;
   localparam int NREG   = 2 ** RW;
   localparam int WB_MAX = 4;

   logic            clk;
   logic            rst;
   logic            flush;
   logic            rd_req_valid;
   logic            rd_req_ready;
   logic [RW-1:0]   rd_req_rs1;
   logic [RW-1:0]   rd_req_rs2;
   logic            rd_req_use_rs2;
   logic [RW-1:0]   rd_req_rd;
   logic            rd_req_rd_en;
   logic            rd_resp_valid;
   logic            wb_valid;
   logic            wb_ready;
   logic [RW-1:0]   wb_rd;
   logic [DW-1:0]   wb_data;
   logic            rf_rd_en;
   logic [RW-1:0]   rf_rd;
   logic [DW-1:0]   rf_rd_din;
   logic            rf_rs1_en;
   logic            rf_rs2_en;
   logic [RW-1:0]   rf_rs1;
   logic [RW-1:0]   rf_rs2;
   logic [NREG-1:0] pending_mask;
   logic            wb_unexpected;

   regfile_access_ctrl #(
      .REG_COUNT    (NREG),
      .WB_BURST_MAX (WB_MAX)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .rd_req_valid   (rd_req_valid),
      .rd_req_ready   (rd_req_ready),
      .rd_req_rs1     (rd_req_rs1),
      .rd_req_rs2     (rd_req_rs2),
      .rd_req_use_rs2 (rd_req_use_rs2),
      .rd_req_rd      (rd_req_rd),
      .rd_req_rd_en   (rd_req_rd_en),
      .rd_resp_valid  (rd_resp_valid),
      .wb_valid       (wb_valid),
      .wb_ready       (wb_ready),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .rf_rd_en       (rf_rd_en),
      .rf_rd          (rf_rd),
      .rf_rd_din      (rf_rd_din),
      .rf_rs1_en      (rf_rs1_en),
      .rf_rs2_en      (rf_rs2_en),
      .rf_rs1         (rf_rs1),
      .rf_rs2         (rf_rs2),
      .pending_mask   (pending_mask),
      .wb_unexpected  (wb_unexpected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file attached to the controller's pins.
   logic [DW-1:0] rf_mem [NREG];
   logic [DW-1:0] rf_q1;
   logic [DW-1:0] rf_q2;
   initial for (int i = 0; i < NREG; i++) rf_mem[i] = '0;
   always @(posedge clk) begin
      if (rf_rd_en)  rf_mem[rf_rd] <= rf_rd_din;
      if (rf_rs1_en) rf_q1 <= rf_mem[rf_rs1];
      if (rf_rs2_en) rf_q2 <= rf_mem[rf_rs2];
   end

   typedef struct {
      int            cyc;
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
      bit            use2;
   } exp_t;
   exp_t exp_q[$];

   // Reference model: architectural values, outstanding-write set, wb grants a waiting read has lost.
   logic [DW-1:0]   m_regs [NREG];
   logic [NREG-1:0] m_pend = '0;
   bit              m_unexp = 1'b0;
   int              m_streak = 0;
   initial for (int i = 0; i < NREG; i++) m_regs[i] = '0;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input int r, input int rv, input int rs1, input int rs2, input int u2,
                       input int rdi, input int rde, input int wv, input int wrd,
                       input logic [DW-1:0] wd, input int fl);
      bit   hz, elig, rdw, wbw;
      exp_t e;
      rst            = (r != 0);
      rd_req_valid   = (rv != 0);
      rd_req_rs1     = RW'(rs1);
      rd_req_rs2     = RW'(rs2);
      rd_req_use_rs2 = (u2 != 0);
      rd_req_rd      = RW'(rdi);
      rd_req_rd_en   = (rde != 0);
      wb_valid       = (wv != 0);
      wb_rd          = RW'(wrd);
      wb_data        = wd;
      flush          = (fl != 0);
      if (r == 0) exp_q.delete();
      @(negedge clk);
      hz = 1'b0; elig = 1'b0; rdw = 1'b0; wbw = 1'b0;
      if (r != 0) begin
         hz   = m_pend[rs1] || (u2 != 0 && m_pend[rs2]) || (rde != 0 && rdi != 0 && m_pend[rdi]);
         elig = (rv != 0) && !hz && (fl == 0);
         rdw  = elig && ((wv == 0) || m_streak >= WB_MAX);
         wbw  = (wv != 0) && !rdw;
      end
      chk("wb_ready",     64'(wb_ready),     64'(wbw));
      chk("rd_req_ready", 64'(rd_req_ready), 64'(rdw));
      chk("rf_rd_en",     64'(rf_rd_en),     64'(wbw && wrd != 0));
      chk("rf_rs1_en",    64'(rf_rs1_en),    64'(rdw));
      chk("rf_rs2_en",    64'(rf_rs2_en),    64'(rdw && u2 != 0));
      if (wbw && wrd != 0) chk("rf_rd", 64'(rf_rd), 64'(wrd));
      if (rdw) chk("rf_rs1", 64'(rf_rs1), 64'(rs1));
      if (r == 0) begin
         m_pend   = '0;
         m_unexp  = 1'b0;
         m_streak = 0;
      end else begin
         if (rdw) begin
            e.cyc  = cyc + 1;
            e.d1   = m_regs[rs1];
            e.d2   = m_regs[rs2];
            e.use2 = (u2 != 0);
            exp_q.push_back(e);
         end
         if (wbw) begin
            if (wrd != 0 && !m_pend[wrd]) m_unexp = 1'b1;
            if (wrd != 0) m_regs[wrd] = wd;
            m_pend[wrd] = 1'b0;
         end
         if (rdw && rde != 0 && rdi != 0) m_pend[rdi] = 1'b1;
         if (fl != 0) m_pend = '0;
         if (rdw) m_streak = 0;
         else if (!elig) begin
            if (m_streak < WB_MAX) m_streak = 0;
         end else if (wbw) m_streak++;
      end
      @(posedge clk);
      #1;
      chk("pending_mask",  64'(pending_mask),  64'(m_pend));
      chk("wb_unexpected", 64'(wb_unexpected), 64'(m_unexp));
   endtask

   task automatic idle();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0);
   endtask

   // Response monitor: every rd_resp_valid must match the oldest outstanding read grant.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rd_resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("resp_unexpected", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk("resp_cycle", 64'(cyc), 64'(e.cyc));
               chk("resp_rs1_data", 64'(rf_q1), 64'(e.d1));
               if (e.use2) chk("resp_rs2_data", 64'(rf_q2), 64'(e.d2));
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("resp_missing", 64'(rd_resp_valid), 64'(1));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
      $fatal(1, "bench time limit reached");
   end

   initial begin
      // Reset holds everything off even with both requesters active.
      step(0, 1, 5, 6, 1, 7, 1, 1, 7, 32'h1111, 0);
      step(0, 1, 5, 6, 1, 7, 1, 1, 7, 32'h1111, 0);

      // Read x5,x6 -> x7 becomes pending.
      step(1, 1, 5, 6, 1, 7, 1, 0, 0, '0, 0);
      // Read of x7 stalls until its writeback, then is granted with the new value.
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, '0, 0);
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, '0, 0);
      step(1, 1, 7, 0, 0, 0, 0, 1, 7, 32'hA5A5_0007, 0);
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, '0, 0);
      idle();

      // Writeback beats an eligible read when no burst has built up.
      step(1, 1, 1, 2, 1, 9, 1, 0, 0, '0, 0);
      step(1, 1, 1, 2, 1, 0, 0, 1, 9, 32'h0000_0909, 0);
      step(1, 1, 1, 2, 1, 0, 0, 0, 0, '0, 0);
      idle();

      // x0 writeback consumes the slot silently; x3 is not pending and flags wb_unexpected.
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_0000, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 3, 32'h0000_0303, 0);
      idle();

      // Six back-to-back writebacks against a hazard-free waiting read.
      for (int k = 0; k < 6; k++) step(1, 1, 1, 2, 1, 0, 0, 1, 3, DW'(32'h3000 + k), 0);
      idle();

      // Pending {x2,x7}; flush alongside a wb to x2 releases the stalled x7 read next cycle.
      step(1, 1, 4, 0, 0, 2, 1, 0, 0, '0, 0);
      step(1, 1, 4, 0, 0, 7, 1, 0, 0, '0, 0);
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, '0, 0);
      step(1, 1, 7, 0, 0, 0, 0, 1, 2, 32'h0000_0222, 1);
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, '0, 0);
      idle();

      // Reset right after a read grant drops that read's response.
      step(1, 1, 1, 2, 1, 5, 1, 0, 0, '0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0);
      idle();

      for (int n = 0; n < 3000; n++) begin
         int wrd;
         int cand[$];
         cand.delete();
         for (int i = 1; i < 8; i++) if (m_pend[i]) cand.push_back(i);
         if (cand.size() > 0 && $urandom_range(3) != 0)
            wrd = cand[$urandom_range(cand.size() - 1)];
         else
            wrd = int'($urandom_range(7));
         step(int'($urandom_range(199) != 0), int'($urandom_range(9) < 7),
              int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(1)),
              int'($urandom_range(7)), int'($urandom_range(9) < 6),
              int'($urandom_range(9) < 6), wrd, DW'($urandom), int'($urandom_range(31) == 0));
      end

      idle();
      idle();
      idle();
      chk("resp_drain", 64'(exp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
